hazard_ctrl_unit: RTL and testbench

//  Pipeline hazard controller for the 5-stage core (IF/ID/EX/MEM/WB). Sequences the ALU

---
 rtl/hazard_ctrl_unit.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, branch flushes, memory freezes,
// registered forward selects for the instruction entering EX, stall counter and memory timeout.
module hazard_ctrl_unit #(
  parameter int RW          = 4,
  parameter int PERF_W      = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  input  logic [RW-1:0]     dec_src_a,
  input  logic [RW-1:0]     dec_src_b,
  input  logic              dec_use_a,
  input  logic              dec_use_b,
  input  logic              ex_valid,
  input  logic              ex_wr,
  input  logic              ex_is_load,
  input  logic [RW-1:0]     ex_dest,
  input  logic              mem_valid,
  input  logic              mem_wr,
  input  logic [RW-1:0]     mem_dest,
  input  logic              mem_busy,
  input  logic              branch_taken,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              bubble_ex,
  output logic              flush_id,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [PERF_W-1:0] stall_count,
  output logic              mem_timeout,
  output logic              fsm_state
);

  // Handshake: none; every control output is a level for the current cycle and the
  // pipeline registers sample it on the same rising edge.

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          timeout_next;

  logic hit_e_a, hit_e_b, hit_m_a, hit_m_b, load_use;
  logic [1:0] sel_a, sel_b;

  assign hit_e_a  = dec_valid & dec_use_a & ex_valid & ex_wr & (ex_dest == dec_src_a);
  assign hit_e_b  = dec_valid & dec_use_b & ex_valid & ex_wr & (ex_dest == dec_src_b);
  assign hit_m_a  = dec_valid & dec_use_a & mem_valid & mem_wr & (mem_dest == dec_src_a);
  assign hit_m_b  = dec_valid & dec_use_b & mem_valid & mem_wr & (mem_dest == dec_src_b);
  assign load_use = (hit_e_a | hit_e_b) & ex_is_load;

  // EX result is younger than MEM result, so it wins when both match.
  assign sel_a = hit_e_a ? 2'b01 : (hit_m_a ? 2'b10 : 2'b00);
  assign sel_b = hit_e_b ? 2'b01 : (hit_m_b ? 2'b10 : 2'b00);

  assign fsm_state = state;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    bubble_ex    = 1'b0;
    flush_id     = 1'b0;
    case (state)
      RUN: begin
        if (mem_busy) begin
          state_next = MEM_WAIT;
          cnt_next   = CW'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        end else begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
    // In both states a busy memory freezes everything; once it drops, the
    // cycle behaves as an ordinary RUN cycle.
    if (!rst_n) begin
      bubble_ex = 1'b1;
    end else if (mem_busy) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
    end else if (branch_taken) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (load_use) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  assign timeout_next = mem_timeout | (mem_busy & (cnt_next == CNT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      cnt         <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
      fwd_a_sel   <= 2'b00;
      fwd_b_sel   <= 2'b00;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      mem_timeout <= timeout_next;
      if (stall_if && (stall_count != {PERF_W{1'b1}})) begin
        stall_count <= stall_count + PERF_W'(1);
      end
      if (stall_ex) begin
        fwd_a_sel <= fwd_a_sel;
        fwd_b_sel <= fwd_b_sel;
      end else if (bubble_ex) begin
        fwd_a_sel <= 2'b00;
        fwd_b_sel <= 2'b00;
      end else begin
        fwd_a_sel <= sel_a;
        fwd_b_sel <= sel_b;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios plus randomized traffic checked
// against a behavioural model of stalls, forwarding, stall counting and timeout.
module tb_hazard_ctrl_unit;

  localparam int RW  = 4;
  localparam int PW  = 8;
  localparam int TMO = 64;
  localparam int SAT = (1 << PW) - 1;

  logic          clk, rst_n;
  logic          dec_valid, dec_use_a, dec_use_b;
  logic [RW-1:0] dec_src_a, dec_src_b;
  logic          ex_valid, ex_wr, ex_is_load;
  logic [RW-1:0] ex_dest;
  logic          mem_valid, mem_wr, mem_busy, branch_taken;
  logic [RW-1:0] mem_dest;
  logic          stall_if, stall_id, stall_ex, bubble_ex, flush_id;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [PW-1:0] stall_count;
  logic          mem_timeout, fsm_state;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [4:0] obs_ctrl, exp_ctrl;  // {stall_if, stall_id, stall_ex, bubble_ex, flush_id}
  logic [1:0] m_fwd_a, m_fwd_b;
  int         m_sc, m_run;
  logic       m_to, m_wait;

  hazard_ctrl_unit #(.RW(RW), .PERF_W(PW), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_src_a(dec_src_a), .dec_src_b(dec_src_b),
    .dec_use_a(dec_use_a), .dec_use_b(dec_use_b),
    .ex_valid(ex_valid), .ex_wr(ex_wr), .ex_is_load(ex_is_load), .ex_dest(ex_dest),
    .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_dest(mem_dest),
    .mem_busy(mem_busy), .branch_taken(branch_taken),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .bubble_ex(bubble_ex), .flush_id(flush_id),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_count(stall_count), .mem_timeout(mem_timeout), .fsm_state(fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic set_idle();
    dec_valid = 0; dec_use_a = 0; dec_use_b = 0; dec_src_a = '0; dec_src_b = '0;
    ex_valid = 0; ex_wr = 0; ex_is_load = 0; ex_dest = '0;
    mem_valid = 0; mem_wr = 0; mem_dest = '0; mem_busy = 0; branch_taken = 0;
  endtask

  task automatic model_reset();
    m_fwd_a = 2'b00; m_fwd_b = 2'b00; m_sc = 0; m_run = 0; m_to = 1'b0; m_wait = 1'b0;
  endtask

  // Which stage currently holds the newest value of register src: 1 = EX, 2 = MEM, 0 = none.
  function automatic logic [1:0] producer(input logic used, input logic [RW-1:0] src);
    if (!(dec_valid && used)) return 2'b00;
    if (ex_valid && ex_wr && ex_dest == src) return 2'b01;
    if (mem_valid && mem_wr && mem_dest == src) return 2'b10;
    return 2'b00;
  endfunction

  // One clock: sample combinational controls, advance the model, cross the rising edge.
  task automatic step();
    logic [1:0] pa, pb;
    logic lu;
    #1;
    obs_ctrl = {stall_if, stall_id, stall_ex, bubble_ex, flush_id};
    pa = producer(dec_use_a, dec_src_a);
    pb = producer(dec_use_b, dec_src_b);
    lu = ex_is_load && (pa == 2'b01 || pb == 2'b01);
    if (mem_busy)          exp_ctrl = 5'b11100;
    else if (branch_taken) exp_ctrl = 5'b00011;
    else if (lu)           exp_ctrl = 5'b11010;
    else                   exp_ctrl = 5'b00000;
    if (!mem_busy) begin
      m_fwd_a = exp_ctrl[1] ? 2'b00 : pa;
      m_fwd_b = exp_ctrl[1] ? 2'b00 : pb;
    end
    if (exp_ctrl[4] && m_sc < SAT) m_sc++;
    m_run = mem_busy ? m_run + 1 : 0;
    if (m_run >= TMO) m_to = 1'b1;
    m_wait = mem_busy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    mem_busy = 1;
    rst_n = 0;
    #3;
    n_cmp++; if ({stall_if, stall_id, stall_ex, bubble_ex, flush_id} !== 5'b00010) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 00010", {stall_if, stall_id, stall_ex, bubble_ex, flush_id}); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_fwd: got %b expected 0000", {fwd_a_sel, fwd_b_sel}); end
    n_cmp++; if (stall_count !== '0 || mem_timeout !== 1'b0 || fsm_state !== 1'b0) begin
      n_bad++; $display("FAIL reset_regs: count %0d timeout %b state %b expected 0 0 0", stall_count, mem_timeout, fsm_state); end
    set_idle();
    rst_n = 1;
    model_reset();
    step();
  endtask

  task automatic test_fwd_ex();
    set_idle();
    ex_valid = 1; ex_wr = 1; ex_dest = 4'd3;
    dec_valid = 1; dec_use_a = 1; dec_src_a = 4'd3; dec_use_b = 1; dec_src_b = 4'd7;
    step();
    n_cmp++; if (obs_ctrl !== 5'b00000) begin
      n_bad++; $display("FAIL fwd_ex_ctrl: got %b expected 00000", obs_ctrl); end
    n_cmp++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin
      n_bad++; $display("FAIL fwd_ex_sel: got a=%b b=%b expected a=01 b=00", fwd_a_sel, fwd_b_sel); end
  endtask

  task automatic test_load_use();
    set_idle();
    ex_valid = 1; ex_wr = 1; ex_is_load = 1; ex_dest = 4'd5;
    dec_valid = 1; dec_use_a = 1; dec_src_a = 4'd1; dec_use_b = 1; dec_src_b = 4'd5;
    step();
    n_cmp++; if (obs_ctrl !== 5'b11010) begin
      n_bad++; $display("FAIL load_use_stall: got %b expected 11010", obs_ctrl); end
    n_cmp++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      n_bad++; $display("FAIL load_use_bubble_sel: got a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel); end
    ex_valid = 0; ex_wr = 0; ex_is_load = 0;
    mem_valid = 1; mem_wr = 1; mem_dest = 4'd5;
    step();
    n_cmp++; if (obs_ctrl !== 5'b00000) begin
      n_bad++; $display("FAIL load_use_release: got %b expected 00000", obs_ctrl); end
    n_cmp++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b10) begin
      n_bad++; $display("FAIL load_use_fwd_mem: got a=%b b=%b expected a=00 b=10", fwd_a_sel, fwd_b_sel); end
  endtask

  task automatic test_ex_priority();
    set_idle();
    ex_valid = 1; ex_wr = 1; ex_dest = 4'd2;
    mem_valid = 1; mem_wr = 1; mem_dest = 4'd2;
    dec_valid = 1; dec_use_a = 1; dec_src_a = 4'd2; dec_use_b = 1; dec_src_b = 4'd2;
    step();
    n_cmp++; if (obs_ctrl !== 5'b00000 || fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin
      n_bad++; $display("FAIL ex_priority: ctrl %b a=%b b=%b expected 00000 01 01", obs_ctrl, fwd_a_sel, fwd_b_sel); end
  endtask

  task automatic test_mem_freeze();
    int sc0;
    sc0 = m_sc;
    dec_src_a = 4'd9; dec_src_b = 4'd10;  // no longer hits: held selects must stay 01
    for (int i = 0; i < 3; i++) begin
      mem_busy = 1;
      branch_taken = (i == 1);
      step();
      n_cmp++; if (obs_ctrl !== 5'b11100) begin
        n_bad++; $display("FAIL freeze_ctrl[%0d]: got %b expected 11100", i, obs_ctrl); end
      n_cmp++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01 || fsm_state !== 1'b1) begin
        n_bad++; $display("FAIL freeze_hold[%0d]: a=%b b=%b state=%b expected 01 01 1", i, fwd_a_sel, fwd_b_sel, fsm_state); end
    end
    mem_busy = 0; branch_taken = 0;
    step();
    n_cmp++; if (obs_ctrl !== 5'b00000 || fsm_state !== 1'b0) begin
      n_bad++; $display("FAIL freeze_exit: ctrl %b state %b expected 00000 0", obs_ctrl, fsm_state); end
    n_cmp++; if (stall_count !== PW'(sc0 + 3) || fwd_a_sel !== 2'b00) begin
      n_bad++; $display("FAIL freeze_count: count %0d a=%b expected %0d 00", stall_count, fwd_a_sel, sc0 + 3); end
  endtask

  task automatic test_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      dec_valid = ($urandom_range(0, 7) != 0);
      dec_use_a = $urandom_range(0, 1); dec_use_b = $urandom_range(0, 1);
      dec_src_a = RW'($urandom_range(0, 3)); dec_src_b = RW'($urandom_range(0, 3));
      ex_valid = $urandom_range(0, 1); ex_wr = $urandom_range(0, 1);
      ex_is_load = ($urandom_range(0, 2) == 0); ex_dest = RW'($urandom_range(0, 3));
      mem_valid = $urandom_range(0, 1); mem_wr = $urandom_range(0, 1);
      mem_dest = RW'($urandom_range(0, 3));
      mem_busy = ($urandom_range(0, 9) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      step();
      n_cmp++; if (obs_ctrl !== exp_ctrl) begin
        n_bad++; $display("FAIL rand_ctrl[%0d]: got %b expected %b", i, obs_ctrl, exp_ctrl); end
      n_cmp++; if (fwd_a_sel !== m_fwd_a || fwd_b_sel !== m_fwd_b) begin
        n_bad++; $display("FAIL rand_fwd[%0d]: got a=%b b=%b expected a=%b b=%b", i, fwd_a_sel, fwd_b_sel, m_fwd_a, m_fwd_b); end
      n_cmp++; if (stall_count !== PW'(m_sc) || mem_timeout !== m_to || fsm_state !== m_wait) begin
        n_bad++; $display("FAIL rand_regs[%0d]: count %0d to %b state %b expected %0d %b %b", i, stall_count, mem_timeout, fsm_state, m_sc, m_to, m_wait); end
    end
  endtask

  task automatic test_timeout();
    set_idle();
    repeat (2) step();
    mem_busy = 1;
    repeat (TMO - 1) step();
    n_cmp++; if (mem_timeout !== 1'b0 || fsm_state !== 1'b1) begin
      n_bad++; $display("FAIL timeout_early: to %b state %b expected 0 1", mem_timeout, fsm_state); end
    step();
    n_cmp++; if (mem_timeout !== 1'b1) begin
      n_bad++; $display("FAIL timeout_set: got %b expected 1", mem_timeout); end
    mem_busy = 0;
    repeat (5) step();
    n_cmp++; if (mem_timeout !== 1'b1 || obs_ctrl !== 5'b00000 || stall_count !== PW'(m_sc)) begin
      n_bad++; $display("FAIL timeout_sticky: to %b ctrl %b count %0d expected 1 00000 %0d", mem_timeout, obs_ctrl, stall_count, m_sc); end
  endtask

  task automatic test_saturation();
    set_idle();
    mem_busy = 1;
    repeat (SAT + 10) step();
    n_cmp++; if (stall_count !== PW'(SAT)) begin
      n_bad++; $display("FAIL sat_busy: got %0d expected %0d", stall_count, SAT); end
    set_idle();
    ex_valid = 1; ex_wr = 1; ex_is_load = 1; ex_dest = 4'd4;
    dec_valid = 1; dec_use_a = 1; dec_src_a = 4'd4;
    repeat (3) step();
    n_cmp++; if (stall_count !== PW'(SAT) || obs_ctrl !== 5'b11010) begin
      n_bad++; $display("FAIL sat_hold: count %0d ctrl %b expected %0d 11010", stall_count, obs_ctrl, SAT); end
  endtask

  task automatic test_reset_mid_wait();
    set_idle();
    ex_valid = 1; ex_wr = 1; ex_dest = 4'd6;
    dec_valid = 1; dec_use_a = 1; dec_src_a = 4'd6;
    step();
    mem_busy = 1;
    repeat (3) step();
    #2;
    rst_n = 0;
    #1;
    n_cmp++; if ({stall_if, stall_id, stall_ex, bubble_ex, flush_id} !== 5'b00010) begin
      n_bad++; $display("FAIL midwait_ctrl: got %b expected 00010", {stall_if, stall_id, stall_ex, bubble_ex, flush_id}); end
    n_cmp++; if (fwd_a_sel !== 2'b00 || stall_count !== '0 || mem_timeout !== 1'b0 || fsm_state !== 1'b0) begin
      n_bad++; $display("FAIL midwait_regs: a=%b count %0d to %b state %b expected 00 0 0 0", fwd_a_sel, stall_count, mem_timeout, fsm_state); end
    @(posedge clk);
    #1;
    set_idle();
    rst_n = 1;
    model_reset();
    step();
    n_cmp++; if (obs_ctrl !== 5'b00000 || stall_count !== '0 || fsm_state !== 1'b0) begin
      n_bad++; $display("FAIL midwait_release: ctrl %b count %0d state %b expected 00000 0 0", obs_ctrl, stall_count, fsm_state); end
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    model_reset();
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_ex_priority();
    test_mem_freeze();
    test_random(200);
    test_timeout();
    test_saturation();
    test_reset_mid_wait();
    test_random(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
